sync_counter_sequencer: RTL and testbench
=========================================

Name: sync_counter_sequencer

Overview:
- Controller that sequences a WIDTH-bit synchronous up/down counter through programmed count passes: load a start value, count toward a terminal value, reload, and repeat for N passes.
- Owns the counter state register q/q_bar and exports the per-cycle toggle-enable t, so an external toggle-flop counter slice can be driven in lockstep.
- Sits between a host issuing start/abort commands and the counter datapath.
- Uses a start/busy/done handshake.

Parameters:
- WIDTH, 3, counter width in bits. Counting is modulo 2^WIDTH.
- LOOP_W, 4, width of the pass-count field.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  command strobe. Sampled only in IDLE.
- dir  input  1  1 = count up, 0 = count down. Latched on accepted start.
- load_val  input  WIDTH  start value. Latched on accepted start.
- term_val  input  WIDTH  terminal value. Latched on accepted start.
- loops  input  LOOP_W  number of passes. 0 is treated as 1. Latched on accepted start.
- pause  input  1  level. Freezes counting while in RUN.
- abort  input  1  level. Cancels the sequence.
- busy  output  1  high in LOAD and RUN.
- done  output  1  one-cycle pulse when the final pass completes.
- wrap  output  1  high in any cycle where a pass boundary is taken.
- t  output  1  count enable for the datapath. Equals (state==RUN && !pause && !abort && q!=term_r).
- q  output  WIDTH  counter value.
- q_bar  output  WIDTH  always ~q.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE; q = 0; q_bar = all ones.
  - busy = done = wrap = t = 0.
  - Latched dir/term/loop registers = 0.
  - Reset asserted mid-sequence aborts immediately. No done pulse.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - q holds.
  - If start = 1 at an edge: latch dir_r, term_r, load_r, and loop_cnt = max(loops, 1). Go to LOAD.
- LOAD (1 cycle): q <= load_r. Go to RUN.
- RUN, evaluated at each edge in priority order:
  - abort = 1: go to IDLE, q holds, no done, no wrap.
  - pause = 1: q holds, state holds, t = 0, wrap = 0.
  - q == term_r (pass boundary): wrap = 1 in this cycle.
    - If loop_cnt == 1: go to DONE, q holds at term_r.
    - Else: loop_cnt decrements, q <= load_r.
  - Otherwise: q <= q+1 (dir_r = 1) or q-1 (dir_r = 0), modulo 2^WIDTH (7->0 up, 0->7 down).
- A pass therefore takes ((term-load) mod 2^WIDTH) steps up, or ((load-term) mod 2^WIDTH) steps down, plus one boundary cycle.
- If load_val == term_val, every RUN cycle is a boundary: wrap stays high and q stays constant.
- DONE (1 cycle): done = 1, busy = 0. Go to IDLE. start is ignored in DONE.
- start while busy: ignored. Latched values are unaffected.
- abort in IDLE, LOAD or DONE: no effect, except abort in LOAD, which returns to IDLE with q unchanged.
- Input changes to dir/load_val/term_val/loops while busy have no effect.
- wrap and t are combinational from registered state and the pause/abort inputs. done and busy decode state only.

Test Plan:
1. Reset then idle: rst_n low 2 cycles, release -> q=000, q_bar=111, busy=0, done=0, t=0. Outputs stay stable with start=0.
2. Down count: dir=0, load=5, term=2, loops=2; start pulsed at edge E0.
   - busy rises after E0; q=5 after E1.
   - q runs 4, 3, 2 after E2..E4.
   - wrap=1 in the cycle q==2; reload gives q=5 after E5.
   - Second pass: q runs 4, 3, 2 after E6..E8.
   - After E9: DONE, done=1 for exactly 1 cycle, q=2. After E10: IDLE.
3. Up wrap-around: dir=1, load=6, term=1, loops=0 -> q sequence 6, 7, 0, 1. Single pass; done pulses once. t=1 on exactly 3 cycles.
4. Pause/abort:
   - Same setup as scenario 2; hold pause 3 cycles at q=4 -> q=4 frozen, t=0, completion delayed by exactly 3 cycles.
   - Separate run: abort at q=3 -> IDLE next edge, q=3 held, no done.
5. Start while busy: pulse start with load=0 mid-run -> ignored, sequence completes with the original values. Asserting rst_n=0 mid-run -> q=0 asynchronously, busy=0.
6. load==term: load=term=3, loops=3 -> q=3 constant, wrap high for 3 consecutive RUN cycles, then done pulse.

Source files
------------

// File: rtl/sync_counter_sequencer.sv
// Sequences a WIDTH-bit up/down counter through repeated load/count passes under
// a start/busy/done handshake; exports the count enable t for an external counter slice.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start, q holds its last value
// S_LOAD | one cycle, q takes the latched start value
// S_RUN  | counting toward term; pause freezes, abort cancels
// S_DONE | one cycle, done pulse, then back to idle
module sync_counter_sequencer #(
    parameter int WIDTH  = 3,
    parameter int LOOP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dir,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  term_val,
    input  logic [LOOP_W-1:0] loops,
    input  logic              pause,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              wrap,
    output logic              t,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  q_bar
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    load_q, load_d;
    logic [WIDTH-1:0]    term_q, term_d;
    logic                dir_q, dir_d;
    logic [LOOP_W-1:0]   loop_q, loop_d;
    logic                at_term;
    logic                run_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            load_q  <= '0;
            term_q  <= '0;
            dir_q   <= 1'b0;
            loop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            term_q  <= term_d;
            dir_q   <= dir_d;
            loop_q  <= loop_d;
        end
    end

    assign at_term = (cnt_q == term_q);
    assign run_go  = (state_q == S_RUN) && !pause && !abort;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        term_d  = term_q;
        dir_d   = dir_q;
        loop_d  = loop_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_d  = load_val;
                    term_d  = term_val;
                    dir_d   = dir;
                    // a zero pass count still runs one pass
                    loop_d  = (loops == '0) ? LOOP_W'(1) : loops;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = load_q;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!pause) begin
                    if (at_term) begin
                        if (loop_q == LOOP_W'(1)) begin
                            state_d = S_DONE;
                        end else begin
                            loop_d = loop_q - LOOP_W'(1);
                            cnt_d  = load_q;
                        end
                    end else if (dir_q) begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end else begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy  = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign wrap  = run_go && at_term;
    assign t     = run_go && !at_term;
    assign q     = cnt_q;
    assign q_bar = ~cnt_q;

endmodule

// File: tb/tb_sync_counter_sequencer.sv
// Scoreboard bench: the driver pushes the expected per-cycle counter events computed
// from pass arithmetic; a negedge monitor pops and compares whenever t, wrap or done fire.
module tb_sync_counter_sequencer;

    localparam int W   = 3;
    localparam int LW  = 4;
    localparam int MOD = 1 << W;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          dir;
    logic [W-1:0]  load_val;
    logic [W-1:0]  term_val;
    logic [LW-1:0] loops;
    logic          pause;
    logic          abort;
    logic          busy;
    logic          done;
    logic          wrap;
    logic          t;
    logic [W-1:0]  q;
    logic [W-1:0]  q_bar;

    sync_counter_sequencer #(.WIDTH(W), .LOOP_W(LW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dir      (dir),
        .load_val (load_val),
        .term_val (term_val),
        .loops    (loops),
        .pause    (pause),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap),
        .t        (t),
        .q        (q),
        .q_bar    (q_bar)
    );

    typedef struct {
        bit       is_done;
        logic [W-1:0] qv;
        bit       wr;
        int       cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [W-1:0] mon_nb;
    int           cyc = 0;
    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] exp_idle_q = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && (t || wrap || done)) begin
            if (sb.size() == 0) begin
                chk("sb_depth_at_event", 32'(sb.size()), 1);
            end else begin
                mon_e  = sb.pop_front();
                mon_nb = ~mon_e.qv;
                chk("event_cycle", cyc, mon_e.cyc);
                chk("done", done, {31'b0, mon_e.is_done});
                chk("q", {29'b0, q}, {29'b0, mon_e.qv});
                chk("q_bar", {29'b0, q_bar}, {29'b0, mon_nb});
                chk("wrap", wrap, {31'b0, mon_e.wr});
                chk("t", t, {31'b0, !mon_e.is_done && !mon_e.wr});
                chk("busy", busy, {31'b0, !mon_e.is_done});
            end
        end
    end

    // Expected active-cycle values: each pass walks from load to term, then one boundary cycle.
    task automatic build_vals(input bit d, input int ld, input int tm, input int lp,
                              output exp_t vals[$]);
        int   passes;
        int   steps;
        int   v;
        exp_t e;
        vals.delete();
        passes = (lp == 0) ? 1 : lp;
        steps  = d ? (((tm - ld) % MOD) + MOD) % MOD : (((ld - tm) % MOD) + MOD) % MOD;
        for (int p = 0; p < passes; p++) begin
            v = ld;
            for (int k = 0; k < steps; k++) begin
                e = '{0, W'(v), 0, 0};
                vals.push_back(e);
                v = d ? (v + 1) % MOD : (v + MOD - 1) % MOD;
            end
            e = '{0, W'(tm), 1, 0};
            vals.push_back(e);
        end
    endtask

    task automatic check_idle(input string tag);
        logic [W-1:0] nb;
        nb = ~exp_idle_q;
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_t"}, t, 0);
        chk({tag, "_wrap"}, wrap, 0);
        chk({tag, "_q"}, {29'b0, q}, {29'b0, exp_idle_q});
        chk({tag, "_q_bar"}, {29'b0, q_bar}, {29'b0, nb});
        chk({tag, "_sb_empty"}, 32'(sb.size()), 0);
    endtask

    task automatic drive_noise();
        start    = 1'($urandom_range(1));
        dir      = 1'($urandom_range(1));
        load_val = W'($urandom_range(MOD - 1));
        term_val = W'($urandom_range(MOD - 1));
        loops    = LW'($urandom_range(15));
    endtask

    task automatic idle_gap();
        int n;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            abort = 1'($urandom_range(1));
            pause = 1'($urandom_range(1));
            tick();
            check_idle("gap");
        end
        abort = 1'b0;
        pause = 1'b0;
    endtask

    task automatic run_seq(input bit d, input int ld, input int tm, input int lp,
                           input int pause_pct, input int pause_item, input int pause_len,
                           input int abort_item, input bit abort_load, input bit noise);
        exp_t vals[$];
        exp_t e;
        int   idx;
        int   pl;
        build_vals(d, ld, tm, lp, vals);
        idx = 0;
        pl  = pause_len;
        start = 1'b1; dir = d; load_val = W'(ld); term_val = W'(tm); loops = LW'(lp);
        pause = 1'b0; abort = 1'b0;
        tick();
        start = 1'b0;
        if (abort_load) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check_idle("abort_load");
            return;
        end
        if (noise) drive_noise();
        tick();
        while (vals.size() > 0) begin
            start = 1'b0;
            if (noise) drive_noise();
            abort = 1'b0;
            pause = 1'b0;
            if (idx == pause_item && pl > 0) begin
                pause = 1'b1;
                pl--;
            end else if (idx == abort_item) begin
                abort = 1'b1;
                exp_idle_q = vals[0].qv;
                tick();
                abort = 1'b0;
                start = 1'b0;
                check_idle("abort_run");
                return;
            end else if (pause_item < 0 && $urandom_range(99) < pause_pct) begin
                pause = 1'b1;
            end else begin
                e = vals.pop_front();
                e.cyc = cyc;
                sb.push_back(e);
                idx++;
            end
            tick();
        end
        pause = 1'b0;
        e = '{1, W'(tm), 0, cyc};
        sb.push_back(e);
        exp_idle_q = W'(tm);
        start = noise ? 1'b1 : 1'b0;
        tick();
        start = 1'b0;
        tick();
        check_idle("post_done");
    endtask

    task automatic reset_mid_run();
        exp_t vals[$];
        exp_t e;
        build_vals(1'b0, 5, 2, 2, vals);
        start = 1'b1; dir = 1'b0; load_val = 3'd5; term_val = 3'd2; loops = 4'd2;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            e = vals.pop_front();
            e.cyc = cyc;
            sb.push_back(e);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_q", {29'b0, q}, 0);
        chk("async_rst_q_bar", {29'b0, q_bar}, 7);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_idle_q = '0;
        tick();
        check_idle("after_rst");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; dir = 1'b0; load_val = '0; term_val = '0;
        loops = '0; pause = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("reset");
        end

        run_seq(1'b0, 5, 2, 2, 0, -1, 0, -1, 1'b0, 1'b0);
        idle_gap();
        run_seq(1'b1, 6, 1, 0, 0, -1, 0, -1, 1'b0, 1'b0);
        idle_gap();
        run_seq(1'b0, 5, 2, 2, 0, 1, 3, -1, 1'b0, 1'b0);
        idle_gap();
        run_seq(1'b0, 5, 2, 2, 0, -1, 0, 2, 1'b0, 1'b0);
        idle_gap();
        run_seq(1'b1, 2, 6, 2, 0, -1, 0, -1, 1'b0, 1'b1);
        idle_gap();
        run_seq(1'b1, 3, 3, 3, 0, -1, 0, -1, 1'b0, 1'b0);
        idle_gap();
        run_seq(1'b0, 4, 1, 1, 0, -1, 0, -1, 1'b1, 1'b0);
        idle_gap();
        reset_mid_run();
        idle_gap();

        for (int n = 0; n < 40; n++) begin
            int ab;
            ab = ($urandom_range(4) == 0) ? int'($urandom_range(12)) : -1;
            run_seq(1'($urandom_range(1)), int'($urandom_range(MOD - 1)),
                    int'($urandom_range(MOD - 1)), int'($urandom_range(5)),
                    20, -1, 0, ab, ($urandom_range(14) == 0), 1'($urandom_range(1)));
            idle_gap();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
